// File: rtl/core2axi4l_mo_if.sv
// Bus interfaces for core2axi4l_mo: Ibex-style core memory port (core_if) and
// AXI4-Lite (axi4l_if), each with master/slave modports.

interface core_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  gnt;
  logic                  rvalid;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

interface axi4l_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/core2axi4l_mo.sv
// Core req/gnt/rvalid to AXI4-Lite bridge with up to MAX_OUTSTANDING in-order requests.
// Optional macro CORE2AXI4L_REG_RESP_EN registers the core response path.

module core2axi4l_mo #(
  parameter int         ADDR_W          = 32,
  parameter int         DATA_W          = 32,
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [2:0] PROT            = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  core_if.slave      core,
  axi4l_if.master    axi
);

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int                BE_W    = DATA_W / 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt;
  logic              dir;
  logic              aw_pend;
  logic              w_pend;
  logic              ar_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              issue_free;
  logic              gnt;
  logic              resp_hs;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;
  logic              unused_resp_lsb;

  // The issue slot is reusable as soon as every pending channel handshakes this cycle.
  assign issue_free = (!aw_pend || axi.awready) &&
                      (!w_pend  || axi.wready)  &&
                      (!ar_pend || axi.arready);

  // Direction lock keeps responses in request order without any reorder storage.
  assign gnt = rst_n && core.req && issue_free && (cnt < CNT_MAX) &&
               ((cnt == '0) || (core.we == dir));

  // Only the channel matching the locked direction can answer; anything with cnt==0 is spurious.
  assign resp_hs   = (cnt != '0) &&
                     (dir ? (axi.bvalid && axi.bready) : (axi.rvalid && axi.rready));
  assign resp_err  = dir ? axi.bresp[1] : axi.rresp[1];
  assign resp_data = dir ? '0 : axi.rdata;
  assign unused_resp_lsb = axi.bresp[0] ^ axi.rresp[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dir     <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
    end else begin
      if (gnt) dir <= core.we;
      aw_pend <= (gnt &&  core.we) || (aw_pend && !axi.awready);
      w_pend  <= (gnt &&  core.we) || (w_pend  && !axi.wready);
      ar_pend <= (gnt && !core.we) || (ar_pend && !axi.arready);
      if (gnt && !resp_hs)      cnt <= cnt + CNT_ONE;
      else if (!gnt && resp_hs) cnt <= cnt - CNT_ONE;
    end
  end

  // NOTE: payload registers are qualified by the pend flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (gnt) begin
      addr_q  <= core.addr;
      be_q    <= core.be;
      wdata_q <= core.wdata;
    end
  end

  assign core.gnt    = gnt;

  assign axi.awvalid = aw_pend;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = PROT;
  assign axi.wvalid  = w_pend;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.arvalid = ar_pend;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = PROT;
  assign axi.bready  = 1'b1;
  assign axi.rready  = 1'b1;

`ifdef CORE2AXI4L_REG_RESP_EN
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp_hs;
      err_q    <= resp_hs && resp_err;
      rdata_q  <= resp_hs ? resp_data : '0;
    end
  end

  assign core.rvalid = rvalid_q;
  assign core.err    = err_q;
  assign core.rdata  = rdata_q;
`else
  assign core.rvalid = resp_hs;
  assign core.err    = resp_hs && resp_err;
  assign core.rdata  = resp_hs ? resp_data : '0;
`endif

endmodule

// File: doc/core2axi4l_mo.md
# core2axi4l_mo

Parametrised core-to-AXI4-Lite bridge that supports multiple outstanding transactions. It replaces the single-transaction bridge placed between each Ibex memory port (instruction and data) and its AXI4-Lite master interface. It converts the Ibex req/gnt/rvalid protocol into AXI4-Lite AW/W/B/AR/R traffic and keeps up to `MAX_OUTSTANDING` requests in flight. Core responses are returned strictly in request order.

## Interface
Parameters:
- `ADDR_W`, default 32: address width; must match `core` and `axi` interface widths.
- `DATA_W`, default 32: data width, 32 or 64; byte-enable/strobe width is `DATA_W/8`.
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered requests, range 1..8.
- `PROT`, default 3'b000: constant driven on `awprot`/`arprot`; the instruction instance uses 3'b100.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `core`  core_if (slave side)  ADDR_W/DATA_W  Ibex-style req, gnt, rvalid, we, be, addr, wdata, rdata, err.
- `axi`  axi4l_if.master  ADDR_W/DATA_W  AXI4-Lite master: AW, W, B, AR, R channels.

## Operation
- Issue register: one entry holding {we, addr, be, wdata}, plus per-channel pending flags `aw_pend`, `w_pend`, `ar_pend`.
- Grant rule: `gnt = req && issue_free && (cnt < MAX_OUTSTANDING) && (cnt == 0 || we == dir)`.
  - `issue_free` is true when no flag is pending, or when every pending flag completes its handshake in the current cycle.
- On gnt:
  - The request is loaded into the issue register.
  - Write: `aw_pend` and `w_pend` are set. Read: `ar_pend` is set.
  - `dir` is set to `we`.
  - `cnt` increments.
- Channel driving:
  - `awvalid = aw_pend`, `wvalid = w_pend`, `arvalid = ar_pend`.
  - AW and W complete independently; each flag clears on its own valid&&ready.
  - `awaddr` and `araddr` carry `addr` unmodified; `wstrb = be`; prot fields are `PROT`.
- Direction lock: reads and writes are never in flight together, so in-order response delivery needs no reorder buffer. A request in the opposite direction waits (gnt=0) until `cnt == 0`.
- Responses:
  - `bready = rready = 1` always.
  - A B or R handshake with `cnt > 0` produces `core.rvalid = 1` for one cycle and decrements `cnt`.
  - `core.err = resp[1]`, so SLVERR and DECERR report as err and OKAY/EXOKAY do not.
  - `core.rdata = rdata` for reads and 0 for writes.
- Simultaneous gnt and response in one cycle: `cnt` is unchanged.
- Spurious B or R while `cnt == 0`: ignored; no rvalid; `cnt` stays 0.
- `cnt` is `$clog2(MAX_OUTSTANDING+1)` bits wide and never wraps.

## Timing
- Reset values:
  - Core side: gnt 0, rvalid 0, err 0, rdata 0.
  - AXI side: awvalid, wvalid, arvalid 0; bready and rready 1.
  - Internal: `cnt` 0, all pend flags 0, `dir` 0.
- gnt is combinational from `core.req`, `cnt`, and the AXI ready signals in the same cycle.
- awvalid/wvalid/arvalid assert in the cycle after gnt and hold with stable payload until their handshake (AXI rule).
- Back-to-back throughput: one request per cycle when ready signals stay high and the slave responds fast enough.
- Minimum latency from gnt to `core.rvalid` is 2 cycles: address handshake in cycle +1, response in cycle +2 or later.
- Reset mid-transaction:
  - All valids drop immediately and `cnt` clears.
  - In-flight AXI transactions are abandoned; slaves must share the same reset.

## Configuration
- Macro `CORE2AXI4L_REG_RESP_EN`.
- Defined:
  - `core.rvalid`, `core.rdata`, and `core.err` are registered; response latency grows by 1 cycle.
  - `cnt` still decrements on the AXI handshake cycle.
  - A gnt in the same cycle may therefore precede the registered rvalid, and this is legal.
- Undefined: the response path is combinational from the B/R channels to the core as described above.

## Test plan
- Single read: req addr 0x0000_1000, arready=1, R one cycle later with rdata 0xDEAD_BEEF, resp OKAY -> gnt in cycle 0, arvalid in cycle 1, rvalid=1 with rdata 0xDEAD_BEEF and err=0.
- Write with split channels: we=1, be=4'b0011, wdata 0x1234_5678; awready at cycle 1 and wready at cycle 3 -> awvalid drops after cycle 1, wvalid holds until cycle 3 with wstrb 4'b0011; B OKAY -> rvalid with err=0.
- Outstanding limit (MAX_OUTSTANDING=2): 3 back-to-back reads, R withheld -> 2 gnts; third gnt only in the cycle after the first R handshake; 3 rvalids in order.
- Direction lock: read outstanding then write request -> write gnt stays 0 until R returns, then gnt; no overlap between arvalid and awvalid.
- Error response: R resp=2'b10, then B resp=2'b11 -> err=1 on both rvalids; spurious B with cnt=0 -> no rvalid.
- Reset mid-write: rst_n low while awvalid=1 -> awvalid=0 and gnt=0 immediately; after release the first request completes normally.
